// File: rtl/comet_ii_io_pkg.sv
// Shared constants for the COMET II console I/O port: register offsets and STATUS bit positions.
package comet_ii_io_pkg;

  // Word offsets from the block base address
  localparam int unsigned REG_STATUS  = 0;
  localparam int unsigned REG_TXDATA  = 1;
  localparam int unsigned REG_RXDATA  = 2;
  localparam int unsigned REG_RXCOUNT = 3;
  localparam int unsigned NUM_REGS    = 4;

  // STATUS/CTRL bit positions
  localparam int unsigned ST_RX_AVAIL   = 0;
  localparam int unsigned ST_TX_FULL    = 1;
  localparam int unsigned ST_TX_EMPTY   = 2;
  localparam int unsigned ST_RX_OVERRUN = 3;
  localparam int unsigned ST_TX_DROP    = 4;
  localparam int unsigned ST_TX_IE      = 5;
  localparam int unsigned STATUS_W      = 6;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/comet_ii_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; a push into a full FIFO is accepted only with a concurrent pop.
module comet_ii_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge mclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/comet_ii_io_port.sv
// Memory-mapped console port: STATUS/CTRL, TXDATA, RXDATA, RXCOUNT with TX and RX byte FIFOs.
module comet_ii_io_port
  import comet_ii_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        re,
  input  logic [15:0] raddr,
  output logic [15:0] rdata,
  output logic        rhit,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]   roff;
  logic [ADDR_W-1:0]   woff;
  logic                rd_hit;
  logic                wr_hit;
  logic                rd_rxdata;
  logic                wr_txdata;
  logic                wr_status;

  logic                tx_full;
  logic                tx_empty;
  logic [CW-1:0]       tx_count;
  logic                rx_full;
  logic                rx_empty;
  logic [CW-1:0]       rx_count;
  logic [BYTE_W-1:0]   rx_head;

  logic                rx_overrun;
  logic                tx_drop;
  logic                tx_ie;
  logic [STATUS_W-1:0] status;
  logic [DATA_W-1:0]   rdata_d;
  logic                unused_wdata_hi;

  // Address decode; offsets are computed modulo 2^16 so the window may sit anywhere
  assign roff      = raddr - BASE_ADDR;
  assign woff      = waddr - BASE_ADDR;
  assign rd_hit    = re & (roff < ADDR_W'(NUM_REGS));
  assign wr_hit    = we & (woff < ADDR_W'(NUM_REGS));
  assign rd_rxdata = rd_hit & (roff[1:0] == 2'(REG_RXDATA));
  assign wr_txdata = wr_hit & (woff[1:0] == 2'(REG_TXDATA));
  assign wr_status = wr_hit & (woff[1:0] == 2'(REG_STATUS));

  assign unused_wdata_hi = ^wdata[15:8];

  comet_ii_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .mclk  (mclk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (tx_ready),
    .din   (wdata[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  comet_ii_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .mclk  (mclk),
    .rst_n (rst_n),
    .push  (rx_strobe),
    .pop   (rd_rxdata),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_valid = (tx_count != '0);

  // Live status word, sampled pre-edge by STATUS reads
  always_comb begin
    status                = '0;
    status[ST_RX_AVAIL]   = ~rx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_DROP]    = tx_drop;
    status[ST_TX_IE]      = tx_ie;
  end

  // Read data mux; empty RXDATA reads return zero
  always_comb begin
    rdata_d = '0;
    if (rd_hit) begin
      case (roff[1:0])
        2'(REG_STATUS):  rdata_d = DATA_W'(status);
        2'(REG_RXDATA):  if (!rx_empty) rdata_d = {8'h00, rx_head};
        2'(REG_RXCOUNT): rdata_d = DATA_W'(rx_count);
        default:         rdata_d = '0;
      endcase
    end
  end

  // Registered read response
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      rdata <= '0;
      rhit  <= 1'b0;
    end else begin
      rdata <= rdata_d;
      rhit  <= rd_hit;
    end
  end

  // Sticky error bits (set beats clear), interrupt enable and interrupt line
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      tx_ie      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rx_overrun <= (rx_overrun & ~(wr_status & wdata[ST_RX_OVERRUN]))
                  | (rx_strobe & rx_full & ~rd_rxdata);
      tx_drop    <= (tx_drop & ~(wr_status & wdata[ST_TX_DROP]))
                  | (wr_txdata & tx_full & ~tx_ready);
      if (wr_status) tx_ie <= wdata[ST_TX_IE];
      irq        <= ~rx_empty | (tx_empty & tx_ie);
    end
  end

endmodule

// File: tb/tb_comet_ii_io_port.sv
// Bench for comet_ii_io_port: directed scenarios plus random traffic against a queue-based model.
module tb_comet_ii_io_port;

  localparam logic [15:0] BASE = 16'hFFF0;
  localparam int          D    = 8;

  logic        mclk;
  logic        rst_n;
  logic        re;
  logic [15:0] raddr;
  logic [15:0] rdata;
  logic        rhit;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_strobe;
  logic [7:0]  rx_data;
  logic        irq;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_ovr;
  bit          m_drop;
  bit          m_ie;
  logic [15:0] e_rdata;
  bit          e_rhit;
  bit          e_irq;

  comet_ii_io_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .rhit      (rhit),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .irq       (irq)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {10'b0, m_ie, m_drop, m_ovr, (txq.size() == 0), (txq.size() == D), (rxq.size() != 0)};
  endfunction

  // Advance the model by one edge from the current inputs, clock the DUT, compare
  task automatic tick();
    logic [15:0] off_r;
    logic [15:0] off_w;
    int          txn;
    int          rxn;
    bit          tx_pop;
    bit          rx_pop;
    bit          set_drop;
    bit          set_ovr;
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      m_ovr = 0; m_drop = 0; m_ie = 0;
      e_rdata = '0; e_rhit = 0; e_irq = 0;
    end else begin
      e_irq   = (rxq.size() != 0) || ((txq.size() == 0) && m_ie);
      off_r   = raddr - BASE;
      off_w   = waddr - BASE;
      e_rhit  = 0;
      e_rdata = '0;
      rx_pop  = 0;
      set_drop = 0;
      set_ovr  = 0;
      if (re && off_r < 16'd4) begin
        e_rhit = 1;
        case (off_r)
          16'd0: e_rdata = m_status();
          16'd2: if (rxq.size() != 0) begin e_rdata = {8'h00, rxq[0]}; rx_pop = 1; end
          16'd3: e_rdata = 16'(rxq.size());
          default: e_rdata = '0;
        endcase
      end
      txn    = txq.size();
      tx_pop = tx_ready && (txn > 0);
      if (tx_pop) void'(txq.pop_front());
      if (we && off_w == 16'd1) begin
        if (txn < D || tx_pop) txq.push_back(wdata[7:0]);
        else set_drop = 1;
      end
      rxn = rxq.size();
      if (rx_pop) void'(rxq.pop_front());
      if (rx_strobe) begin
        if (rxn < D || rx_pop) rxq.push_back(rx_data);
        else set_ovr = 1;
      end
      if (we && off_w == 16'd0) begin
        if (wdata[3]) m_ovr = 0;
        if (wdata[4]) m_drop = 0;
        m_ie = wdata[5];
      end
      if (set_drop) m_drop = 1;
      if (set_ovr)  m_ovr  = 1;
    end
    @(posedge mclk);
    #1;
    check("rdata", 32'(rdata), 32'(e_rdata));
    check("rhit", 32'(rhit), 32'(e_rhit));
    check("irq", 32'(irq), 32'(e_irq));
    check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
    re = 0;
    we = 0;
    rx_strobe = 0;
  endtask

  task automatic rd(input int off);
    re = 1; raddr = BASE + 16'(off);
    tick();
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    we = 1; waddr = BASE + 16'(off); wdata = d;
    tick();
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_strobe = 1; rx_data = b;
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 0; re = 0; raddr = '0; we = 0; waddr = '0; wdata = '0;
    tx_ready = 0; rx_strobe = 0; rx_data = '0;
    #1;
    tick(); tick();
    rst_n = 1;

    // Reset state and address decode
    rd(0);
    check("rst_status", 32'(rdata), 32'h0004);
    check("rst_rhit", 32'(rhit), 32'd1);
    re = 1; raddr = 16'h0000; tick();
    check("oow_rhit", 32'(rhit), 32'd0);
    check("oow_rdata", 32'(rdata), 32'd0);

    // Single TX byte
    wr(1, 16'hAB41);
    check("tx1_valid", 32'(tx_valid), 32'd1);
    check("tx1_data", 32'(tx_data), 32'h41);
    tx_ready = 1; tick(); tx_ready = 0;
    check("tx1_drained", 32'(tx_valid), 32'd0);
    rd(0);
    check("tx1_empty_bit", 32'(rdata[2]), 32'd1);

    // TX overflow and drain order
    for (int i = 1; i <= 9; i++) wr(1, 16'(i));
    rd(0);
    check("txf_full_bit", 32'(rdata[1]), 32'd1);
    check("txf_drop_bit", 32'(rdata[4]), 32'd1);
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      check("drain", 32'(tx_data), 32'(i));
      tick();
    end
    tx_ready = 0;
    check("drain_done", 32'(tx_valid), 32'd0);
    wr(0, 16'h0010);
    rd(0);
    check("drop_cleared", 32'(rdata[4]), 32'd0);

    // RX two bytes and irq
    strobe(8'h10);
    strobe(8'h20);
    rd(3);
    check("rx_count2", 32'(rdata), 32'd2);
    check("rx_irq", 32'(irq), 32'd1);
    rd(2);
    check("rx_b0", 32'(rdata), 32'h0010);
    rd(2);
    check("rx_b1", 32'(rdata), 32'h0020);
    check("irq_hold", 32'(irq), 32'd1);
    rd(2);
    check("rx_empty_rd", 32'(rdata), 32'd0);
    check("irq_drop", 32'(irq), 32'd0);

    // RX overrun and full with concurrent pop
    for (int i = 0; i < 9; i++) strobe(8'(8'h30 + i));
    rd(0);
    check("ovr_bit", 32'(rdata[3]), 32'd1);
    rd(3);
    check("rx_count8", 32'(rdata), 32'd8);
    re = 1; raddr = BASE + 16'd2; rx_strobe = 1; rx_data = 8'h99; tick();
    check("full_pop_data", 32'(rdata), 32'h0030);
    rd(3);
    check("full_pop_count", 32'(rdata), 32'd8);

    // Reset mid-stream with an in-flight read
    for (int i = 0; i < 3; i++) wr(1, 16'(8'hC0 + i));
    rst_n = 0; re = 1; raddr = BASE; tick(); rst_n = 1;
    check("mrst_txv", 32'(tx_valid), 32'd0);
    check("mrst_rdata", 32'(rdata), 32'd0);
    check("mrst_rhit", 32'(rhit), 32'd0);
    rd(3);
    check("mrst_rxcount", 32'(rdata), 32'd0);
    rd(0);
    check("mrst_status", 32'(rdata), 32'h0004);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      re        = 1'($urandom);
      raddr     = ($urandom_range(0, 3) != 0) ? BASE + 16'($urandom_range(0, 4)) : 16'($urandom);
      we        = 1'($urandom);
      waddr     = ($urandom_range(0, 3) != 0) ? BASE + 16'($urandom_range(0, 4)) : 16'($urandom);
      wdata     = 16'($urandom);
      tx_ready  = ($urandom_range(0, 2) == 0);
      rx_strobe = 1'($urandom);
      rx_data   = 8'($urandom);
      tick();
    end
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
